// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - scan FSM state type and BCM on-time helpers for the HUB75 scan controller
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY
    } scan_state_t;

    // Binary-coded modulation: each plane is displayed twice as long as the one below it.
    function automatic int unsigned oe_cycles(input int unsigned base, input int unsigned plane);
        return base << plane;
    endfunction

    function automatic int unsigned oe_on_cycles(input int unsigned base, input int unsigned plane,
                                                 input logic [7:0] brightness);
        return ((base << plane) * 32'(brightness)) >> 8;
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// rtl/hub75_scan_ctrl_if.sv - framebuffer read bus between the scan controller and pixel memory
interface hub75_scan_ctrl_if #(
    parameter int unsigned COLUMNS   = 64,
    parameter int unsigned SCAN_ROWS = 32,
    parameter int unsigned PLANES    = 4
);
    logic                          fb_re;
    logic [$clog2(SCAN_ROWS)-1:0]  fb_row;
    logic [$clog2(COLUMNS)-1:0]    fb_col;
    logic [6*PLANES-1:0]           fb_data;

    modport master (output fb_re, output fb_row, output fb_col, input fb_data);
    modport slave  (input fb_re, input fb_row, input fb_col, output fb_data);
endinterface

// File: rtl/hub75_bcm_timer.sv
// rtl/hub75_bcm_timer.sv - down-counter that times one DISPLAY period
module hub75_bcm_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count,
    output logic [WIDTH-1:0] remaining,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign remaining = cnt;
    // Terminal at 1 so a period of N load cycles spans exactly N counting cycles.
    assign done      = cnt <= WIDTH'(1);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 LED panel row scanner with binary-coded modulation
// Optional HUB75_BRIGHTNESS_EN adds an 8-bit global brightness input that trims oe_n on-time.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned COLUMNS   = 64,
    parameter int unsigned SCAN_ROWS = 32,
    parameter int unsigned PLANES    = 4,
    parameter int unsigned OE_BASE   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                   brightness,
`endif
    hub75_scan_ctrl_if.master            fb,
    output logic [2:0]                   rgb0,
    output logic [2:0]                   rgb1,
    output logic                         display_clk,
    output logic                         latch,
    output logic                         oe_n,
    output logic [$clog2(SCAN_ROWS)-1:0] row_addr,
    output logic                         frame_start
);

    localparam int unsigned CW = $clog2(COLUMNS);
    localparam int unsigned RW = $clog2(SCAN_ROWS);
    localparam int unsigned PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int unsigned TW = $clog2(OE_BASE << (PLANES - 1)) + 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(COLUMNS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

    scan_state_t   state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic          armed;
    logic [2:0]    rgb0_q, rgb1_q;
    logic [5:0]    pix_bits;
    logic          col_step, plane_step;
    logic          tmr_load, tmr_count, tmr_done;
    logic [TW-1:0] tmr_val, tmr_remaining;
    logic          oe_on;

    // Pick bit [plane] out of each {r0,g0,b0,r1,g1,b1} channel field.
    for (genvar k = 0; k < 6; k++) begin : g_chan
        logic [PLANES-1:0] chan_shift;
        assign chan_shift  = fb.fb_data[(5-k)*PLANES +: PLANES] >> plane;
        assign pix_bits[5-k] = chan_shift[0];
    end

    assign tmr_val = TW'(oe_cycles(OE_BASE, 32'(plane)));

    hub75_bcm_timer #(.WIDTH(TW)) u_bcm_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .count     (tmr_count),
        .remaining (tmr_remaining),
        .done      (tmr_done)
    );

`ifdef HUB75_BRIGHTNESS_EN
    logic [31:0] on_cycles, disp_len;
    assign disp_len  = oe_cycles(OE_BASE, 32'(plane));
    assign on_cycles = oe_on_cycles(OE_BASE, 32'(plane), brightness);
    // remaining counts down from disp_len, so the first on_cycles of the period satisfy this.
    assign oe_on     = (32'(tmr_remaining) + on_cycles) > disp_len;
`else
    assign oe_on     = tmr_remaining != '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_step    = 1'b0;
        plane_step  = 1'b0;
        tmr_load    = 1'b0;
        tmr_count   = 1'b0;
        fb.fb_re    = 1'b0;
        fb.fb_row   = row;
        fb.fb_col   = col;
        rgb0        = rgb0_q;
        rgb1        = rgb1_q;
        display_clk = 1'b0;
        latch       = 1'b0;
        oe_n        = 1'b1;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                // armed keeps the first FETCH off the first edge after reset release
                if (enable && armed) state_nxt = FETCH;
            end
            FETCH: begin
                fb.fb_re    = 1'b1;
                frame_start = (row == '0) && (plane == '0) && (col == '0);
                state_nxt   = SHIFT_LO;
            end
            SHIFT_LO: begin
                rgb0      = pix_bits[5:3];
                rgb1      = pix_bits[2:0];
                state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                display_clk = 1'b1;
                col_step    = 1'b1;
                state_nxt   = (col == COL_LAST) ? BLANK : FETCH;
            end
            BLANK: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                latch     = 1'b1;
                tmr_load  = 1'b1;
                state_nxt = DISPLAY;
            end
            DISPLAY: begin
                oe_n      = !oe_on;
                tmr_count = 1'b1;
                if (tmr_done) begin
                    plane_step = 1'b1;
                    if (plane != PLANE_LAST || enable) state_nxt = FETCH;
                    else                               state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            col      <= '0;
            row      <= '0;
            plane    <= '0;
            rgb0_q   <= '0;
            rgb1_q   <= '0;
            row_addr <= '0;
        end else begin
            armed <= 1'b1;
            if (state == SHIFT_LO) begin
                rgb0_q <= pix_bits[5:3];
                rgb1_q <= pix_bits[2:0];
            end
            if (col_step) begin
                if (col == COL_LAST) begin
                    col      <= '0;
                    row_addr <= row;
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (plane_step) begin
                if (plane == PLANE_LAST) begin
                    plane <= '0;
                    row   <= row + RW'(1);
                end else begin
                    plane <= plane + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - self-checking bench for hub75_scan_ctrl against a frame-level panel model
module tb_hub75_scan_ctrl;

    localparam int C   = 4;
    localparam int R   = 4;
    localparam int P   = 2;
    localparam int OEB = 2;
    localparam int DW  = 6 * P;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] rgb0, rgb1;
    logic       display_clk, latch, oe_n, frame_start;
    logic [$clog2(R)-1:0] row_addr;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0] brightness;
`endif

    logic [DW-1:0] mem [R][C];
    int n_vec    = 0;
    int n_err    = 0;
    int fs_count = 0;
    int frame_no = 0;

    hub75_scan_ctrl_if #(.COLUMNS(C), .SCAN_ROWS(R), .PLANES(P)) fb_bus ();

    hub75_scan_ctrl #(.COLUMNS(C), .SCAN_ROWS(R), .PLANES(P), .OE_BASE(OEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .fb          (fb_bus),
        .rgb0        (rgb0),
        .rgb1        (rgb1),
        .display_clk (display_clk),
        .latch       (latch),
        .oe_n        (oe_n),
        .row_addr    (row_addr),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pixel memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fb_bus.fb_re) fb_bus.fb_data <= mem[fb_bus.fb_row][fb_bus.fb_col];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_start === 1'b1) begin
            fs_count++;
            check("fs_re", fb_bus.fb_re, 1);
            check("fs_addr", {fb_bus.fb_row, fb_bus.fb_col}, 0);
        end
    end

    function automatic logic [2:0] exp_rgb(input logic [DW-1:0] w, input int p, input int half);
        logic [2:0]    res;
        logic [DW-1:0] f;
        for (int k = 0; k < 3; k++) begin
            f = w >> ((5 - (half * 3 + k)) * P + p);
            res[2-k] = f[0];
        end
        return res;
    endfunction

    function automatic int exp_len(input int p);
`ifdef HUB75_BRIGHTNESS_EN
        return ((OEB << p) * int'(brightness)) >> 8;
`else
        return OEB << p;
`endif
    endfunction

    task automatic expect_plane(input int r, input int p, input bit drop_en);
        int waited;
        int extra;
        int low;
        for (int c = 0; c < C; c++) begin
            waited = 0;
            do begin @(negedge clk); waited++; end while (!display_clk && waited < 64);
            check("dclk_seen", display_clk, 1);
            check("rgb0", rgb0, exp_rgb(mem[r][c], p, 0));
            check("rgb1", rgb1, exp_rgb(mem[r][c], p, 1));
            check("oe_shift", oe_n, 1);
            if (p > 0) check("row_hold", row_addr, r);
            if (drop_en && c == 1) enable = 1'b0;
        end
        waited = 0;
        extra  = 0;
        do begin
            @(negedge clk);
            waited++;
            if (display_clk) extra++;
        end while (!latch && waited < 16);
        check("latch_seen", latch, 1);
        check("extra_dclk", extra, 0);
        check("latch_row", row_addr, r);
        check("latch_oe", oe_n, 1);
        waited = 0;
        do begin @(negedge clk); waited++; end while (oe_n && waited < 16);
        low = 0;
        while (!oe_n && low < 1000) begin
            low++;
            @(negedge clk);
        end
        check("oe_len", low, exp_len(p));
    endtask

    task automatic run_row(input int r, input bit drop_en);
        for (int p = 0; p < P; p++) begin
            expect_plane(r, p, (p == 0) ? drop_en : 1'b0);
            if (r == 0 && p == 0) check("fs_count", fs_count, frame_no);
        end
        for (int c = 0; c < C; c++) mem[r][c] = DW'($urandom);
    endtask

    initial begin
        int busy;
        int waited;
        rst_n  = 1'b0;
        enable = 1'b1;
`ifdef HUB75_BRIGHTNESS_EN
        brightness = 8'd128;
`endif
        fb_bus.fb_data = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mem[r][c] = (r < 2) ? DW'(12'hAAA) : DW'($urandom);

        repeat (3) @(negedge clk);
        check("rst_oe", oe_n, 1);
        check("rst_re", fb_bus.fb_re, 0);
        check("rst_dclk", display_clk, 0);
        check("rst_latch", latch, 0);
        check("rst_rgb", {rgb0, rgb1}, 0);
        check("rst_row", row_addr, 0);
        check("rst_fs", frame_start, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("arm_edge1", fb_bus.fb_re, 0);
        @(negedge clk);
        check("arm_edge2", fb_bus.fb_re, 1);
        check("arm_fs", frame_start, 1);

        frame_no = 1;
        for (int r = 0; r < R; r++) run_row(r, 1'b0);

        frame_no = 2;
        run_row(0, 1'b0);
        run_row(1, 1'b1);
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (fb_bus.fb_re || display_clk || latch || !oe_n) busy++;
        end
        check("idle_busy", busy, 0);
        enable = 1'b1;
        run_row(2, 1'b0);
        run_row(3, 1'b0);

        frame_no = 3;
        run_row(0, 1'b0);
        run_row(1, 1'b0);
        expect_plane(2, 0, 1'b0);
        waited = 0;
        do begin @(negedge clk); waited++; end while (oe_n && waited < 100);
        check("pre_rst_oe", oe_n, 0);
        check("pre_rst_row", row_addr, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_oe", oe_n, 1);
        check("mid_rst_re", fb_bus.fb_re, 0);
        check("mid_rst_rgb", {rgb0, rgb1}, 0);
        check("mid_rst_ctl", {display_clk, latch, frame_start}, 0);
        check("mid_rst_row", row_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        frame_no = 4;
        run_row(0, 1'b0);
        check("fs_total", fs_count, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
